// File: rtl/loopback_tester_pkg.sv
// Shared types and constants for the loopback tester: FSM states, LFSR seed/taps, error counter limits.
package loopback_tester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Feedback taps at bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  localparam int             ERR_W   = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  function automatic logic [7:0] lfsr_next(input logic [7:0] w);
    return {w[6:0], ^(w & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lb_delay_line.sv
// Shift register carrying {valid, expected word}; a runtime tap picks the loop latency (tap 0 = pass-through).
module lb_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [3:0]       tap_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid_i;
      for (int i = 1; i < DEPTH; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Data needs no reset: it is only observed together with a valid token.
  always_ff @(posedge clk) begin
    dat_q[0] <= in_data_i;
    for (int i = 1; i < DEPTH; i++) dat_q[i] <= dat_q[i-1];
  end

  always_comb begin
    out_valid_o = in_valid_i;
    out_data_o  = in_data_i;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_i == 4'(i + 1)) begin
        out_valid_o = vld_q[i];
        out_data_o  = dat_q[i];
      end
    end
  end

endmodule

// File: rtl/loopback_tester.sv
// Loopback tester: drives a pattern into an external loop and counts mismatches on the return path.
// Define LOOPBACK_TESTER_LFSR_EN for an 8-bit LFSR pattern; otherwise an incrementing counter is used.
module loopback_tester
  import loopback_tester_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_DELAY = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      cfg_len,
  input  logic [3:0]       cfg_delay,
  output logic [WIDTH-1:0] lb_out,
  input  logic [WIDTH-1:0] lb_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output state_e           dbg_state_o
);

  localparam logic [3:0] MAX_D = 4'(MAX_DELAY);

`ifdef LOOPBACK_TESTER_LFSR_EN
  if (WIDTH != 8) begin : g_width_chk
    $error("loopback_tester: LFSR pattern requires WIDTH == 8");
  end
  localparam logic [WIDTH-1:0] FIRST_WORD = WIDTH'(LFSR_SEED);
  function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] w);
    return WIDTH'(lfsr_next(8'(w)));
  endfunction
`else
  localparam logic [WIDTH-1:0] FIRST_WORD = WIDTH'(1);
  function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] w);
    return w + WIDTH'(1);
  endfunction
`endif

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [3:0]       dly_q, dly_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;

  logic             tok_vld;
  logic [WIDTH-1:0] tok_exp;
  logic [3:0]       dly_clamp;

  assign dly_clamp = (cfg_delay > MAX_D) ? MAX_D : cfg_delay;

  // Words enter the line in the cycle they are driven, so tap 0 compares combinationally.
  lb_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DELAY)
  ) u_dly (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (state_q == ST_RUN),
    .in_data_i   (pat_q),
    .tap_i       (dly_q),
    .out_valid_o (tok_vld),
    .out_data_o  (tok_exp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dly_q   <= '0;
      pat_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      pat_q   <= pat_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    pat_d   = pat_q;
    err_d   = err_q;
    pass_d  = pass_q;
    if (tok_vld && (lb_in != tok_exp) && (err_q != ERR_MAX)) err_d = err_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d = '0;
          dly_d = dly_clamp;
          if (cfg_len != 16'd0) begin
            state_d = ST_RUN;
            cnt_d   = cfg_len;
            pat_d   = FIRST_WORD;
          end else begin
            state_d = ST_DONE;
            pass_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        pat_d = next_word(pat_q);
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          if (dly_q == 4'd0) begin
            state_d = ST_DONE;
            pass_d  = (err_d == '0);
          end else begin
            state_d = ST_DRAIN;
            cnt_d   = 16'(dly_q);
          end
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lb_out      = (state_q == ST_RUN) ? pat_q : '0;
    busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done        = (state_q == ST_DONE);
    pass        = pass_q;
    err_cnt     = err_q;
    dbg_state_o = state_q;
  end

endmodule
